xilly_stream_host: RTL
======================

// Module: xilly_stream_host
// PURPOSE
// Synthesizable host-side endpoint of the 32-bit Xillybus stream pair: opens both streams, pushes
// NUM_WORDS packed 16-bit sample pairs into user_w_write_32 and drains/checks user_r_read_32.
// Sits opposite xillydemo in loopback self-test builds and in the system bench; reports pass/fail.
// PARAMETERS
// NUM_WORDS   1024  32-bit words sent and expected back per run (1..65535)
// XFORM_ADD   0     value the core under test adds to each 16-bit sample (mod 2^16)
// OPEN_DELAY  5     cycles both *_open are high before first wren/rden
// TIMEOUT     4096  max cycles without a received word before the run aborts
// PORTS
// bus_clk               in   1   single clock
// bus_rst_n             in   1   synchronous, active-low reset
// start                 in   1   pulse in IDLE begins a run; ignored otherwise
// busy                  out  1   high from start accept until DONE
// done                  out  1   high in DONE until next start
// pass                  out  1   valid with done: all words received, err_count==0, no timeout
// err_count             out  16  mismatching words (saturates at 16'hFFFF)
// words_sent            out  16  words written this run
// words_recv            out  16  words read this run
// timed_out             out  1   sticky per run
// user_w_write_32_wren  out  1   write strobe
// user_w_write_32_data  out  32  {sample 2k+1, sample 2k}
// user_w_write_32_full  in   1   write FIFO full
// user_w_write_32_open  out  1   write stream open
// user_r_read_32_rden   out  1   read strobe
// user_r_read_32_data   in   32  read data, valid cycle after accepted rden
// user_r_read_32_empty  in   1   read FIFO empty
// user_r_read_32_open   out  1   read stream open
// BEHAVIOUR
// - Reset (bus_rst_n low at posedge): state IDLE; every output 0; counters 0. Reset mid-run aborts
//   immediately, opens drop same edge; no done pulse.
// - FSM: IDLE -start-> OPEN (opens high, count OPEN_DELAY) -> RUN -> DRAIN (words_sent==NUM_WORDS)
//   -> CLOSE (opens low, 2 cycles) -> DONE -start-> OPEN (counters/flags cleared on accept).
//   RUN/DRAIN -> CLOSE when words_recv==NUM_WORDS; DRAIN or RUN -> CLOSE on timeout, timed_out=1.
// - Write: wren = (RUN) & (words_sent<NUM_WORDS) & ~full; combinational on registered state and full,
//   never high while full. Word k data = {16'(2k+1), 16'(2k)}; data register advances only on wren.
// - Read: rden = (RUN|DRAIN) & (words_recv<NUM_WORDS) & ~empty. Accepted read (rden&~empty)
//   sets a 1-cycle valid; data sampled next cycle, compared to {16'(2j+1+XFORM_ADD),16'(2j+XFORM_ADD)}
//   for j = words_recv; words_recv increments at sample. Mismatch -> err_count+1 (saturating).
// - Simultaneous write and read each cycle allowed; independent counters. Reads may precede last write.
// - Timeout counter clears on every sampled word and on RUN entry; terminal count TIMEOUT-1.
// - Pending read valid at CLOSE entry is still sampled/checked. Extra words after NUM_WORDS not read.
// - 16-bit sample arithmetic wraps mod 2^16 (NUM_WORDS>32768 wraps sample values).
// - pass = done & ~timed_out & (err_count==0) & (words_recv==NUM_WORDS).
// STRUCTURE
// - Package xilly_stream_pkg: state enum (IDLE, OPEN, RUN, DRAIN, CLOSE, DONE), SAMPLE_W=16,
//   WORD_W=32, pack_pair(lo,hi) function shared by generator and checker.
// - Sub-module xilly_pair_gen: counter-driven {2k+1,2k}+offset generator with advance strobe;
//   instantiated twice (offset 0 for write, XFORM_ADD for expected read).
// - Top holds FSM, wren/rden gating, read valid pipeline, compare, counters, timeout.
// TESTING
// - Identity loopback FIFO depth 16, NUM_WORDS=1024: done within ~1100 cycles, pass=1, err=0, recv=1024.
// - Loopback adding 1 per sample, XFORM_ADD=1: word0 read 32'h0002_0001, pass=1; XFORM_ADD=0: err=1024.
// - full forced high 50 cycles in RUN: wren stays 0, data held at last value; run then completes, pass=1.
// - Responder drops word 7 (never delivered): timeout after 4096 idle cycles, timed_out=1, recv=1023, pass=0.
// - bus_rst_n low 1 cycle at words_sent=300: next cycle all outputs 0, IDLE; new start reruns cleanly.
// - start pulsed during RUN and with empty/full toggling every cycle: ignored; no wren-while-full, pass=1.

Source files
------------

// File: rtl/xilly_stream_pkg.sv
// Shared types and helpers for the Xillybus 32-bit stream-pair host endpoint.
// The generator and the checker both build words through pack_pair.
package xilly_stream_pkg;

  localparam int SAMPLE_W = 16;
  localparam int WORD_W   = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OPEN  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    CLOSE = 3'd4,
    DONE  = 3'd5
  } state_t;

  function automatic logic [WORD_W-1:0] pack_pair(
    input logic [SAMPLE_W-1:0] lo,
    input logic [SAMPLE_W-1:0] hi
  );
    return {hi, lo};
  endfunction

endpackage

// File: rtl/xilly_stream_host_if.sv
// Write/read stream pair between the host endpoint (master) and the core under test (slave).
interface xilly_stream_host_if;
  import xilly_stream_pkg::*;

  logic              user_w_write_32_wren;
  logic [WORD_W-1:0] user_w_write_32_data;
  logic              user_w_write_32_full;
  logic              user_w_write_32_open;
  logic              user_r_read_32_rden;
  logic [WORD_W-1:0] user_r_read_32_data;
  logic              user_r_read_32_empty;
  logic              user_r_read_32_open;

  modport master (
    output user_w_write_32_wren, user_w_write_32_data, user_w_write_32_open,
    output user_r_read_32_rden, user_r_read_32_open,
    input  user_w_write_32_full, user_r_read_32_data, user_r_read_32_empty
  );

  modport slave (
    input  user_w_write_32_wren, user_w_write_32_data, user_w_write_32_open,
    input  user_r_read_32_rden, user_r_read_32_open,
    output user_w_write_32_full, user_r_read_32_data, user_r_read_32_empty
  );

endinterface

// File: rtl/xilly_pair_gen.sv
// Produces word k = {2k+1+OFFSET, 2k+OFFSET} (16-bit wrap); steps to k+1 on i_advance.
module xilly_pair_gen
  import xilly_stream_pkg::*;
#(
  parameter logic [SAMPLE_W-1:0] OFFSET = 16'd0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_advance,
  output logic [WORD_W-1:0] o_word
);

  logic [SAMPLE_W-1:0] r_lo;
  logic [SAMPLE_W-1:0] w_hi;

  // Low sample of the current pair; high sample is always one above it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_lo <= OFFSET;
    end else if (i_clear) begin
      r_lo <= OFFSET;
    end else if (i_advance) begin
      r_lo <= r_lo + 16'd2;
    end
  end

  assign w_hi   = r_lo + 16'd1;
  assign o_word = pack_pair(r_lo, w_hi);

endmodule

// File: rtl/xilly_stream_host.sv
// Host-side loopback self-test: opens both streams, writes NUM_WORDS sample pairs,
// reads them back, checks each against the expected transform and reports pass/fail.
module xilly_stream_host
  import xilly_stream_pkg::*;
#(
  parameter int NUM_WORDS  = 1024,
  parameter int XFORM_ADD  = 0,
  parameter int OPEN_DELAY = 5,
  parameter int TIMEOUT    = 4096
) (
  input  logic                i_bus_clk,
  input  logic                i_bus_rst_n,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_pass,
  output logic [15:0]         o_err_count,
  output logic [15:0]         o_words_sent,
  output logic [15:0]         o_words_recv,
  output logic                o_timed_out,
  xilly_stream_host_if.master if_stream
);

  localparam int OD_W = (OPEN_DELAY > 1) ? $clog2(OPEN_DELAY) : 1;
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [OD_W-1:0]     OD_LAST = OD_W'(OPEN_DELAY - 1);
  localparam logic [TO_W-1:0]     TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [15:0]         NUM_W   = 16'(NUM_WORDS);
  localparam logic [SAMPLE_W-1:0] XF      = SAMPLE_W'(XFORM_ADD);

  state_t            r_state;
  state_t            w_next_state;
  logic [15:0]       r_words_sent;
  logic [15:0]       r_words_recv;
  logic [15:0]       r_err_count;
  logic              r_timed_out;
  logic              r_rd_valid;
  logic [OD_W-1:0]   r_open_cnt;
  logic              r_close_cnt;
  logic [TO_W-1:0]   r_to_cnt;

  logic              w_start_acc;
  logic              w_sent_done;
  logic              w_recv_done;
  logic              w_recv_room;
  logic              w_in_xfer;
  logic              w_timeout;
  logic              w_mismatch;
  logic              w_open;
  logic              w_busy;
  logic              w_done;
  logic              w_wren;
  logic              w_rden;
  logic [WORD_W-1:0] w_wr_word;
  logic [WORD_W-1:0] w_exp_word;

  assign w_start_acc = i_start & ((r_state == IDLE) | (r_state == DONE));
  assign w_sent_done = (r_words_sent == NUM_W);
  assign w_recv_done = (r_words_recv == NUM_W);
  assign w_in_xfer   = (r_state == RUN) | (r_state == DRAIN);
  // A read still in flight counts against the budget so no word beyond NUM_WORDS is pulled.
  assign w_recv_room = (({1'b0, r_words_recv} + {16'd0, r_rd_valid}) < {1'b0, NUM_W});
  assign w_timeout   = w_in_xfer & (r_to_cnt == TO_LAST) & ~r_rd_valid;
  assign w_mismatch  = (if_stream.user_r_read_32_data != w_exp_word);

  // State register.
  always_ff @(posedge i_bus_clk) begin
    if (!i_bus_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    w_next_state = i_start ? OPEN : IDLE;
      OPEN:    w_next_state = (r_open_cnt == OD_LAST) ? RUN : OPEN;
      RUN: begin
        if (w_recv_done || w_timeout) begin
          w_next_state = CLOSE;
        end else if (w_sent_done) begin
          w_next_state = DRAIN;
        end else begin
          w_next_state = RUN;
        end
      end
      DRAIN:   w_next_state = (w_recv_done || w_timeout) ? CLOSE : DRAIN;
      CLOSE:   w_next_state = r_close_cnt ? DONE : CLOSE;
      DONE:    w_next_state = i_start ? OPEN : DONE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output decode and stream strobes.
  always_comb begin
    w_open = 1'b0;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE:  w_busy = 1'b0;
      OPEN, RUN, DRAIN: begin
        w_open = 1'b1;
        w_busy = 1'b1;
      end
      CLOSE: w_busy = 1'b1;
      DONE:  w_done = 1'b1;
      default: begin
        w_open = 1'b0;
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
    w_wren = (r_state == RUN) & ~w_sent_done & ~if_stream.user_w_write_32_full;
    w_rden = w_in_xfer & w_recv_room & ~if_stream.user_r_read_32_empty;
  end

  // Per-run result counters; cleared when a start is accepted.
  always_ff @(posedge i_bus_clk) begin
    if (!i_bus_rst_n || w_start_acc) begin
      r_words_sent <= 16'd0;
      r_words_recv <= 16'd0;
      r_err_count  <= 16'd0;
      r_timed_out  <= 1'b0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_rd_valid <= w_rden;
      if (w_wren) begin
        r_words_sent <= r_words_sent + 16'd1;
      end
      if (r_rd_valid) begin
        r_words_recv <= r_words_recv + 16'd1;
        if (w_mismatch && (r_err_count != 16'hFFFF)) begin
          r_err_count <= r_err_count + 16'd1;
        end
      end
      if (w_timeout && !w_recv_done) begin
        r_timed_out <= 1'b1;
      end
    end
  end

  // Phase timers: open settle, close hold and receive watchdog.
  always_ff @(posedge i_bus_clk) begin
    if (!i_bus_rst_n) begin
      r_open_cnt  <= '0;
      r_close_cnt <= 1'b0;
      r_to_cnt    <= '0;
    end else begin
      r_open_cnt  <= (r_state == OPEN) ? r_open_cnt + OD_W'(1) : '0;
      r_close_cnt <= (r_state == CLOSE) ? ~r_close_cnt : 1'b0;
      r_to_cnt    <= (w_in_xfer && !r_rd_valid && !w_timeout) ? r_to_cnt + TO_W'(1) : '0;
    end
  end

  xilly_pair_gen #(.OFFSET(16'd0)) u_wr_gen (
    .i_clk     (i_bus_clk),
    .i_rst_n   (i_bus_rst_n),
    .i_clear   (w_start_acc),
    .i_advance (w_wren),
    .o_word    (w_wr_word)
  );

  xilly_pair_gen #(.OFFSET(XF)) u_exp_gen (
    .i_clk     (i_bus_clk),
    .i_rst_n   (i_bus_rst_n),
    .i_clear   (w_start_acc),
    .i_advance (r_rd_valid),
    .o_word    (w_exp_word)
  );

  assign if_stream.user_w_write_32_wren = w_wren;
  assign if_stream.user_w_write_32_data = w_open ? w_wr_word : 32'd0;
  assign if_stream.user_w_write_32_open = w_open;
  assign if_stream.user_r_read_32_rden  = w_rden;
  assign if_stream.user_r_read_32_open  = w_open;

  assign o_busy       = w_busy;
  assign o_done       = w_done;
  assign o_pass       = w_done & ~r_timed_out & (r_err_count == 16'd0) & w_recv_done;
  assign o_err_count  = r_err_count;
  assign o_words_sent = r_words_sent;
  assign o_words_recv = r_words_recv;
  assign o_timed_out  = r_timed_out;

endmodule
